// File: rtl/iic_cfg_pkg.sv
// ---------------------------------------------------------------------------
// iic_cfg_pkg
// Shared definitions for the I2C configuration sequencer: the sequencer
// state encoding, the table entry layout and the two reserved register
// values that act as in-table commands instead of device writes.
// Optional feature macro used by the sequencer: IIC_CFG_READBACK_EN.
// ---------------------------------------------------------------------------
package iic_cfg_pkg;

  // Width of one table entry: {register[15:0], data[7:0]}
  localparam int ENTRY_W = 24;

  // Reserved register values interpreted by the sequencer itself
  localparam logic [15:0] REG_END   = 16'hFFFF;
  localparam logic [15:0] REG_DELAY = 16'hFFFE;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    ISSUE,
    WAIT_ACK,
    WAIT_END,
    CHECK,
    DELAY,
    DONE,
    FAIL
  } state_t;

  // Register field of a table entry
  function automatic logic [15:0] entry_reg(input logic [ENTRY_W-1:0] e);
    return e[ENTRY_W-1:8];
  endfunction

  // Data field of a table entry
  function automatic logic [7:0] entry_data(input logic [ENTRY_W-1:0] e);
    return e[7:0];
  endfunction

endpackage

// File: rtl/iic_cfg_delay.sv
// ---------------------------------------------------------------------------
// iic_cfg_delay
// Loadable down-counter used by the sequencer's DELAY state. A load sets
// the count; the counter then decrements once per clock and pulses done_o
// for one cycle on the clock it reaches zero. Loading zero never pulses.
//
// Ports
//   clk_i       in   sequencer clock
//   rst         in   synchronous active-high reset
//   load_i      in   load load_val_i into the counter (wins over counting)
//   load_val_i  in   number of cycles to count
//   done_o      out  one-cycle pulse when the count expires
// ---------------------------------------------------------------------------
module iic_cfg_delay #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // Next count: load has priority, otherwise count down to zero and stop.
  // The done pulse is raised on the 1 -> 0 step.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d  = cnt_q - CNT_W'(1);
      done_d = (cnt_q == CNT_W'(1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/iic_cfg_seq.sv
// ---------------------------------------------------------------------------
// iic_cfg_seq
// Walks a configuration table and turns each entry into an I2C register
// write through an external byte-level I2C driver. Entries with register
// 16'hFFFF end the table, entries with register 16'hFFFE wait for
// data*DLY_UNIT clocks. NACKed writes are re-issued up to RETRY_MAX times.
//
// Optional feature (macro IIC_CFG_READBACK_EN): every successful write is
// followed by a read of the same register; a read error or a value that
// differs from the written data counts as a failed attempt. Without the
// macro no read is ever issued and drv_wr_rd_flag is tied low.
//
// Ports
//   clk_i            in   clock shared with the I2C driver
//   rst              in   synchronous active-high reset
//   cfg_start        in   one-cycle request to run the table from entry 0
//   tbl_addr         out  table index
//   tbl_data         in   {reg[15:0], data[7:0]}, valid one cycle after
//                         tbl_addr changes
//   drv_start_en     out  driver start request, held until busy is seen
//   drv_wr_rd_flag   out  0 = write, 1 = read
//   drv_dev_addr     out  device address (constant DEV_ADDR)
//   drv_register     out  register address for the transfer
//   drv_data_byte    out  data byte for writes
//   drv_busy         in   driver transfer in progress
//   drv_err          in   driver saw a NACK on the last transfer
//   drv_rd_data      in   byte returned by the last read
//   cfg_busy         out  sequence running
//   cfg_done         out  sequence completed (held)
//   cfg_fail         out  sequence aborted (held)
//   fail_index       out  table index of the failing entry
// ---------------------------------------------------------------------------
module iic_cfg_seq
  import iic_cfg_pkg::*;
#(
  parameter int         TBL_DEPTH = 64,
  parameter logic [7:0] DEV_ADDR  = 8'h78,
  parameter int         RETRY_MAX = 3,
  parameter int         DLY_UNIT  = 8000,
  parameter int         BUSY_TO   = 64
) (
  input  logic               clk_i,
  input  logic               rst,
  input  logic               cfg_start,
  output logic [7:0]         tbl_addr,
  input  logic [ENTRY_W-1:0] tbl_data,
  output logic               drv_start_en,
  output logic               drv_wr_rd_flag,
  output logic [7:0]         drv_dev_addr,
  output logic [15:0]        drv_register,
  output logic [7:0]         drv_data_byte,
  input  logic               drv_busy,
  input  logic               drv_err,
  input  logic [7:0]         drv_rd_data,
  output logic               cfg_busy,
  output logic               cfg_done,
  output logic               cfg_fail,
  output logic [7:0]         fail_index
);

  // One extra index bit so that "index == TBL_DEPTH" is representable
  // for TBL_DEPTH up to 256.
  localparam int IDX_W = 9;
  localparam int RT_W  = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam int TO_W  = (BUSY_TO < 1) ? 1 : $clog2(BUSY_TO + 1);
  localparam int DLY_W = $clog2(255 * DLY_UNIT + 1);

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [RT_W-1:0]    retry_q;
  logic [TO_W-1:0]    to_q;
  logic [15:0]        reg_q;
  logic [7:0]         data_q;
  logic [7:0]         tbl_addr_q;
  logic               start_q;
  logic               busy_q;
  logic               done_q;
  logic               fail_q;
  logic [7:0]         fidx_q;
  logic               dly_load_q;
  logic [DLY_W-1:0]   dly_val_q;

  logic [IDX_W-1:0]   idx_next_d;
  logic               idx_last_d;
  logic               dly_done;
  logic               chk_ok_d;
  logic               chk_next_rd_d;
  logic               advance_d;

`ifdef IIC_CFG_READBACK_EN
  logic               rd_phase_q;
  logic               wr_rd_q;

  // An attempt succeeds when the driver ACKed and, on the read half,
  // the returned byte equals what was written.
  assign chk_ok_d      = !drv_err && (!rd_phase_q || (drv_rd_data == data_q));
  assign chk_next_rd_d = chk_ok_d && !rd_phase_q;
  assign drv_wr_rd_flag = wr_rd_q;
`else
  logic               unused_rd_data;

  assign chk_ok_d       = !drv_err;
  assign chk_next_rd_d  = 1'b0;
  assign drv_wr_rd_flag = 1'b0;
  assign unused_rd_data = ^drv_rd_data;
`endif

  assign idx_next_d = idx_q + IDX_W'(1);
  assign idx_last_d = (idx_next_d == IDX_W'(TBL_DEPTH));

  // All the ways an entry can finish and move the sequence forward:
  // a zero-length delay, an expired delay, or a fully successful transfer.
  always_comb begin
    advance_d = 1'b0;
    case (state_q)
      DECODE:  advance_d = (entry_reg(tbl_data) == REG_DELAY) &&
                           (entry_data(tbl_data) == 8'h00);
      DELAY:   advance_d = dly_done;
      CHECK:   advance_d = chk_ok_d && !chk_next_rd_d;
      default: advance_d = 1'b0;
    endcase
  end

  iic_cfg_delay #(
    .CNT_W (DLY_W)
  ) u_delay (
    .clk_i      (clk_i),
    .rst        (rst),
    .load_i     (dly_load_q),
    .load_val_i (dly_val_q),
    .done_o     (dly_done)
  );

  // Sequencer FSM with registered outputs. The index-advance handling
  // sits after the state case so that it overrides whatever the case
  // did for the three states that can finish an entry.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      retry_q    <= '0;
      to_q       <= '0;
      reg_q      <= '0;
      data_q     <= '0;
      tbl_addr_q <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      fidx_q     <= '0;
      dly_load_q <= 1'b0;
      dly_val_q  <= '0;
`ifdef IIC_CFG_READBACK_EN
      rd_phase_q <= 1'b0;
      wr_rd_q    <= 1'b0;
`endif
    end else begin
      dly_load_q <= 1'b0;

      case (state_q)
        IDLE, DONE, FAIL: begin
          if (cfg_start) begin
            idx_q      <= '0;
            tbl_addr_q <= '0;
            retry_q    <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            fidx_q     <= '0;
`ifdef IIC_CFG_READBACK_EN
            rd_phase_q <= 1'b0;
`endif
            state_q    <= FETCH;
          end
        end

        // tbl_addr was updated on the way in; the table answers next cycle
        FETCH: begin
          state_q <= DECODE;
        end

        DECODE: begin
          reg_q  <= entry_reg(tbl_data);
          data_q <= entry_data(tbl_data);
          if (entry_reg(tbl_data) == REG_END) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (entry_reg(tbl_data) == REG_DELAY) begin
            if (entry_data(tbl_data) != 8'h00) begin
              dly_load_q <= 1'b1;
              dly_val_q  <= DLY_W'(entry_data(tbl_data)) * DLY_W'(DLY_UNIT);
              state_q    <= DELAY;
            end
          end else begin
            state_q <= ISSUE;
          end
        end

        // Never request a transfer while the driver is still busy
        ISSUE: begin
          if (!drv_busy) begin
            start_q <= 1'b1;
            to_q    <= '0;
`ifdef IIC_CFG_READBACK_EN
            wr_rd_q <= rd_phase_q;
`endif
            state_q <= WAIT_ACK;
          end
        end

        // Hold the start request until the driver reports busy, or give
        // up after BUSY_TO cycles of silence.
        WAIT_ACK: begin
          if (drv_busy) begin
            start_q <= 1'b0;
            state_q <= WAIT_END;
          end else if (to_q == TO_W'(BUSY_TO - 1)) begin
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            fail_q  <= 1'b1;
            fidx_q  <= idx_q[7:0];
            state_q <= FAIL;
          end else begin
            to_q <= to_q + TO_W'(1);
          end
        end

        WAIT_END: begin
          if (!drv_busy) begin
            state_q <= CHECK;
          end
        end

        CHECK: begin
          if (chk_next_rd_d) begin
`ifdef IIC_CFG_READBACK_EN
            rd_phase_q <= 1'b1;
`endif
            state_q <= ISSUE;
          end else if (!chk_ok_d) begin
            if (retry_q < RT_W'(RETRY_MAX)) begin
              retry_q <= retry_q + RT_W'(1);
`ifdef IIC_CFG_READBACK_EN
              rd_phase_q <= 1'b0;
`endif
              state_q <= ISSUE;
            end else begin
              busy_q  <= 1'b0;
              fail_q  <= 1'b1;
              fidx_q  <= idx_q[7:0];
              state_q <= FAIL;
            end
          end
        end

        DELAY: begin
          state_q <= DELAY;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase

      // Entry finished: move to the next index, or complete when the
      // table runs out without an end marker.
      if (advance_d) begin
        retry_q <= '0;
`ifdef IIC_CFG_READBACK_EN
        rd_phase_q <= 1'b0;
`endif
        if (idx_last_d) begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end else begin
          idx_q      <= idx_next_d;
          tbl_addr_q <= idx_next_d[7:0];
          state_q    <= FETCH;
        end
      end
    end
  end

  assign tbl_addr      = tbl_addr_q;
  assign drv_start_en  = start_q;
  assign drv_dev_addr  = DEV_ADDR;
  assign drv_register  = reg_q;
  assign drv_data_byte = data_q;
  assign cfg_busy      = busy_q;
  assign cfg_done      = done_q;
  assign cfg_fail      = fail_q;
  assign fail_index    = fidx_q;

endmodule

// File: tb/tb_iic_cfg_seq.sv
// ---------------------------------------------------------------------------
// tb_iic_cfg_seq
// Directed bench for iic_cfg_seq: a registered table model, a small I2C
// driver model with programmable NACK / no-busy / bad-readback behaviour,
// and hand-computed expectations for each scenario.
// ---------------------------------------------------------------------------
module tb_iic_cfg_seq;

  localparam int         TBL_DEPTH = 8;
  localparam logic [7:0] DEV_ADDR  = 8'h78;
  localparam int         RETRY_MAX = 3;
  localparam int         DLY_UNIT  = 10;
  localparam int         BUSY_TO   = 16;

  logic        clk_i = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [7:0]  tbl_addr;
  logic [23:0] tbl_data = '0;
  logic        drv_start_en;
  logic        drv_wr_rd_flag;
  logic [7:0]  drv_dev_addr;
  logic [15:0] drv_register;
  logic [7:0]  drv_data_byte;
  logic        drv_busy = 1'b0;
  logic        drv_err = 1'b0;
  logic [7:0]  drv_rd_data = '0;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_fail;
  logic [7:0]  fail_index;

  iic_cfg_seq #(
    .TBL_DEPTH (TBL_DEPTH),
    .DEV_ADDR  (DEV_ADDR),
    .RETRY_MAX (RETRY_MAX),
    .DLY_UNIT  (DLY_UNIT),
    .BUSY_TO   (BUSY_TO)
  ) dut (
    .clk_i          (clk_i),
    .rst            (rst),
    .cfg_start      (cfg_start),
    .tbl_addr       (tbl_addr),
    .tbl_data       (tbl_data),
    .drv_start_en   (drv_start_en),
    .drv_wr_rd_flag (drv_wr_rd_flag),
    .drv_dev_addr   (drv_dev_addr),
    .drv_register   (drv_register),
    .drv_data_byte  (drv_data_byte),
    .drv_busy       (drv_busy),
    .drv_err        (drv_err),
    .drv_rd_data    (drv_rd_data),
    .cfg_busy       (cfg_busy),
    .cfg_done       (cfg_done),
    .cfg_fail       (cfg_fail),
    .fail_index     (fail_index)
  );

  always #5 clk_i = ~clk_i;

  // Free-running cycle count used to timestamp driver requests
  int cyc = 0;
  always @(posedge clk_i) cyc = cyc + 1;

  int checks = 0;
  int errors = 0;

  // Table model: the address is captured mid-cycle and the data appears
  // just after the following edge, i.e. one cycle after tbl_addr changes.
  logic [23:0] tbl [0:255];
  logic [7:0]  addrS = '0;
  always @(negedge clk_i) addrS = tbl_addr;
  always @(posedge clk_i) begin
    #1;
    tbl_data = tbl[addrS];
  end

  // Driver model knobs and request log
  bit          noBusy = 1'b0;
  bit          rdBad = 1'b0;
  logic [15:0] nackReg = 16'h0000;
  int          nackLeft = 0;
  logic [7:0]  lastWr = '0;
  bit          busySeen = 1'b0;
  logic [15:0] logReg[$];
  logic [7:0]  logData[$];
  bit          logRd[$];
  int          logT[$];

  // Driver model: answers a start request with busy for three cycles,
  // then reports ACK/NACK and (for reads) the returned byte.
  initial begin : driverModel
    logic [15:0] r;
    logic [7:0]  d;
    logic        f;
    logic        e;
    forever begin
      @(posedge clk_i);
      #1;
      if (drv_start_en) begin
        r = drv_register;
        d = drv_data_byte;
        f = drv_wr_rd_flag;
        logReg.push_back(r);
        logData.push_back(d);
        logRd.push_back(f);
        logT.push_back(cyc);
        if (noBusy) begin
          while (drv_start_en) begin
            @(posedge clk_i);
            #1;
          end
        end else begin
          drv_busy = 1'b1;
          repeat (3) @(posedge clk_i);
          #1;
          e = 1'b0;
          if (r == nackReg && nackLeft != 0) begin
            e = 1'b1;
            if (nackLeft > 0) nackLeft = nackLeft - 1;
          end
          if (!e && !f) lastWr = d;
          drv_rd_data = rdBad ? 8'h00 : lastWr;
          drv_err  = e;
          drv_busy = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Clears the log and pulses cfg_start for one cycle
  task automatic applyStimulus();
    logReg.delete();
    logData.delete();
    logRd.delete();
    logT.delete();
    busySeen = 1'b0;
    cfg_start = 1'b1;
    @(posedge clk_i);
    #1;
    cfg_start = 1'b0;
  endtask

  task automatic waitEnd(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_i);
      #1;
      if (cfg_busy) busySeen = 1'b1;
      if (cfg_done || cfg_fail) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_finished"}, 32'(ok), 32'd1);
  endtask

  function automatic int countIssues(input logic [15:0] r, input bit rd, input bit anyReg);
    int n;
    n = 0;
    foreach (logReg[i])
      if ((anyReg || logReg[i] == r) && logRd[i] == rd) n++;
    return n;
  endfunction

  function automatic int nthWrite(input int k);
    int n;
    n = 0;
    foreach (logReg[i]) begin
      if (!logRd[i]) begin
        if (n == k) return i;
        n++;
      end
    end
    return -1;
  endfunction

  function automatic logic [31:0] wrEntry(input int k);
    int i;
    i = nthWrite(k);
    if (i < 0) return 32'hDEAD_BEEF;
    return {8'h00, logReg[i], logData[i]};
  endfunction

  // Gap between the last request of entry 3012 and the first of entry 3013
  // with a delay entry of the given length between them
  task automatic measureGap(input logic [7:0] dly, output int gap);
    int lastA;
    int firstB;
    tbl[0] = 24'h301201;
    tbl[1] = {16'hFFFE, dly};
    tbl[2] = 24'h301302;
    tbl[3] = 24'hFFFF00;
    applyStimulus();
    waitEnd($sformatf("delay%0d", dly), 2000);
    lastA  = -1;
    firstB = -1;
    foreach (logReg[i]) begin
      if (logReg[i] == 16'h3012) lastA = i;
      if (logReg[i] == 16'h3013 && firstB < 0) firstB = i;
    end
    gap = (lastA >= 0 && firstB >= 0) ? (logT[firstB] - logT[lastA]) : -1000;
  endtask

  localparam int RB = `ifdef IIC_CFG_READBACK_EN 1 `else 0 `endif;

  initial begin : mainSeq
    int gap0;
    int gap1;
    int gap3;
    int t0;
    int t1;
    bit seen;

    for (int i = 0; i < 256; i++) tbl[i] = 24'hFFFF00;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("rst_busy", 32'(cfg_busy), 32'd0);
    checkOutput("rst_done", 32'(cfg_done), 32'd0);
    checkOutput("rst_fail", 32'(cfg_fail), 32'd0);
    checkOutput("rst_start_en", 32'(drv_start_en), 32'd0);
    checkOutput("rst_tbl_addr", 32'(tbl_addr), 32'd0);
    checkOutput("dev_addr", 32'(drv_dev_addr), 32'h78);
    rst = 1'b0;
    @(posedge clk_i);
    #1;

    // Two writes then end marker
    tbl[0] = 24'h301201;
    tbl[1] = 24'h301302;
    tbl[2] = 24'hFFFF00;
    applyStimulus();
    waitEnd("basic", 1000);
    checkOutput("basic_done", 32'(cfg_done), 32'd1);
    checkOutput("basic_fail", 32'(cfg_fail), 32'd0);
    checkOutput("basic_busy_after", 32'(cfg_busy), 32'd0);
    checkOutput("basic_busy_during", 32'(busySeen), 32'd1);
    checkOutput("basic_nwrites", 32'(countIssues(16'h0, 1'b0, 1'b1)), 32'd2);
    checkOutput("basic_nreads", 32'(countIssues(16'h0, 1'b1, 1'b1)), 32'(2 * RB));
    checkOutput("basic_wr0", wrEntry(0), 32'h00301201);
    checkOutput("basic_wr1", wrEntry(1), 32'h00301302);
    checkOutput("basic_tbl_addr", 32'(tbl_addr), 32'd2);
    repeat (5) @(posedge clk_i);
    #1;
    checkOutput("basic_done_held", 32'(cfg_done), 32'd1);

    // Delay entries: each unit is DLY_UNIT cycles, zero skips the wait
    measureGap(8'h03, gap3);
    measureGap(8'h01, gap1);
    measureGap(8'h00, gap0);
    checkOutput("delay_3_minus_1", 32'(gap3 - gap1), 32'(2 * DLY_UNIT));
    checkOutput("delay_zero_shorter", 32'(gap0 < gap1), 32'd1);
    checkOutput("delay_done", 32'(cfg_done), 32'd1);

    // Entry 1 NACKed twice then ACKed
    tbl[0] = 24'h301201;
    tbl[1] = 24'h301302;
    tbl[2] = 24'hFFFF00;
    nackReg  = 16'h3013;
    nackLeft = 2;
    applyStimulus();
    waitEnd("retry", 2000);
    checkOutput("retry_issues", 32'(countIssues(16'h3013, 1'b0, 1'b0)), 32'd3);
    checkOutput("retry_done", 32'(cfg_done), 32'd1);
    checkOutput("retry_fail", 32'(cfg_fail), 32'd0);

    // Entry 2 always NACKed; a cfg_start while running must be ignored
    tbl[0] = 24'h301201;
    tbl[1] = 24'h301302;
    tbl[2] = 24'h301403;
    tbl[3] = 24'hFFFF00;
    nackReg  = 16'h3014;
    nackLeft = -1;
    applyStimulus();
    repeat (20) @(posedge clk_i);
    #1;
    cfg_start = 1'b1;
    @(posedge clk_i);
    #1;
    cfg_start = 1'b0;
    waitEnd("nack", 2000);
    checkOutput("nack_issues", 32'(countIssues(16'h3014, 1'b0, 1'b0)), 32'd4);
    checkOutput("nack_total_writes", 32'(countIssues(16'h0, 1'b0, 1'b1)), 32'd6);
    checkOutput("nack_fail", 32'(cfg_fail), 32'd1);
    checkOutput("nack_done", 32'(cfg_done), 32'd0);
    checkOutput("nack_fail_index", 32'(fail_index), 32'd2);
    checkOutput("nack_busy", 32'(cfg_busy), 32'd0);
    nackLeft = 0;

    // Driver never raises busy
    tbl[0] = 24'h301201;
    tbl[1] = 24'hFFFF00;
    noBusy = 1'b1;
    applyStimulus();
    t0 = -1;
    t1 = -1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk_i);
      #1;
      if (drv_start_en && t0 < 0) t0 = cyc;
      if (cfg_fail) begin
        t1 = cyc;
        break;
      end
    end
    checkOutput("busyto_cycles", 32'(t1 - t0), 32'(BUSY_TO));
    checkOutput("busyto_fail_index", 32'(fail_index), 32'd0);
    checkOutput("busyto_start_low", 32'(drv_start_en), 32'd0);
    noBusy = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;

    // Restart from FAIL
    tbl[0] = 24'h305505;
    tbl[1] = 24'hFFFF00;
    applyStimulus();
    waitEnd("restart", 1000);
    checkOutput("restart_done", 32'(cfg_done), 32'd1);
    checkOutput("restart_fail", 32'(cfg_fail), 32'd0);
    checkOutput("restart_wr0", wrEntry(0), 32'h00305505);

    // Table runs out without an end marker
    for (int i = 0; i < TBL_DEPTH; i++) tbl[i] = {16'h4000 + 16'(i), 8'(i)};
    tbl[TBL_DEPTH] = 24'h500000;
    applyStimulus();
    waitEnd("depth", 3000);
    checkOutput("depth_done", 32'(cfg_done), 32'd1);
    checkOutput("depth_writes", 32'(countIssues(16'h0, 1'b0, 1'b1)), 32'(TBL_DEPTH));
    checkOutput("depth_last", wrEntry(TBL_DEPTH - 1), 32'h00400707);
    checkOutput("depth_tbl_addr", 32'(tbl_addr), 32'(TBL_DEPTH - 1));

`ifdef IIC_CFG_READBACK_EN
    // Readback returns the wrong byte every time
    tbl[0] = 24'h301201;
    tbl[1] = 24'hFFFF00;
    rdBad = 1'b1;
    applyStimulus();
    waitEnd("rdbk", 3000);
    checkOutput("rdbk_writes", 32'(countIssues(16'h3012, 1'b0, 1'b0)), 32'd4);
    checkOutput("rdbk_reads", 32'(countIssues(16'h3012, 1'b1, 1'b0)), 32'd4);
    checkOutput("rdbk_fail", 32'(cfg_fail), 32'd1);
    checkOutput("rdbk_fail_index", 32'(fail_index), 32'd0);
    rdBad = 1'b0;
`else
    checkOutput("no_reads_issued", 32'(countIssues(16'h0, 1'b1, 1'b1)), 32'd0);
`endif

    // Reset while waiting for the end of a transfer
    tbl[0] = 24'h301201;
    tbl[1] = 24'h301302;
    tbl[2] = 24'hFFFF00;
    applyStimulus();
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_i);
      #2;
      if (drv_busy) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("midrst_busy_seen", 32'(seen), 32'd1);
    @(posedge clk_i);
    #1;
    checkOutput("midrst_pre_busy", 32'(cfg_busy), 32'd1);
    rst = 1'b1;
    @(posedge clk_i);
    #1;
    rst = 1'b0;
    checkOutput("midrst_busy", 32'(cfg_busy), 32'd0);
    checkOutput("midrst_done", 32'(cfg_done), 32'd0);
    checkOutput("midrst_fail", 32'(cfg_fail), 32'd0);
    checkOutput("midrst_fail_index", 32'(fail_index), 32'd0);
    checkOutput("midrst_tbl_addr", 32'(tbl_addr), 32'd0);
    checkOutput("midrst_start_en", 32'(drv_start_en), 32'd0);
    checkOutput("midrst_register", 32'(drv_register), 32'd0);
    checkOutput("midrst_data", 32'(drv_data_byte), 32'd0);
    checkOutput("midrst_wr_rd", 32'(drv_wr_rd_flag), 32'd0);
    repeat (10) @(posedge clk_i);
    #1;
    checkOutput("midrst_stays_idle", 32'(cfg_busy || drv_start_en), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
